// File: rtl/gowin_rpll_ctrl_if.sv
// ---------------------------------------------------------------------------
// gowin_rpll_ctrl_if
// Settings-request channel into the rPLL reconfiguration controller.
//
// Handshake: the master holds req_valid and every req_* payload field stable
// until it sees req_ready high at a rising clock edge. A transfer happens on
// exactly that edge (req_valid && req_ready). req_ready never depends
// combinationally on req_valid.
//
// Signals:
//   req_valid   master -> slave  request present
//   req_ready   slave  -> master controller can accept this cycle
//   req_full    master -> slave  1 = divider change (PLL reset), 0 = phase/duty
//   req_idsel   master -> slave  IDSEL   (used when req_full = 1)
//   req_fbdsel  master -> slave  FBDSEL  (used when req_full = 1)
//   req_odsel   master -> slave  ODSEL   (used when req_full = 1)
//   req_psda    master -> slave  PSDA
//   req_dutyda  master -> slave  DUTYDA
// ---------------------------------------------------------------------------
interface gowin_rpll_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_full;
  logic [5:0] req_idsel;
  logic [5:0] req_fbdsel;
  logic [5:0] req_odsel;
  logic [3:0] req_psda;
  logic [3:0] req_dutyda;

  modport master (
    output req_valid, req_full, req_idsel, req_fbdsel, req_odsel,
           req_psda, req_dutyda,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_full, req_idsel, req_fbdsel, req_odsel,
           req_psda, req_dutyda,
    output req_ready
  );
endinterface

// File: rtl/gowin_rpll_ctrl.sv
// ---------------------------------------------------------------------------
// gowin_rpll_ctrl
// Run-time reconfiguration and lock supervisor for one Gowin rPLL with
// dynamic IDIV/FBDIV/ODIV selects and dynamic phase/duty. Clocked from the
// PLL reference input.
//
// Ports:
//   clkin        reference clock, all logic on its rising edge
//   reset        synchronous, active-high
//   req          settings request channel (slave side)
//   pll_lock     rPLL LOCK, asynchronous (2-flop synchronised here)
//   pll_reset    to rPLL RESET
//   idsel/fbdsel/odsel/psda/dutyda   to rPLL dynamic select ports
//   locked       PLL stable and in use
//   busy         high except in IDLE and ERROR
//   done         one-cycle pulse on a successful lock or settle
//   err          high in ERROR
//   state_o      current FSM state (debug)
// All outputs are registered.
// ---------------------------------------------------------------------------
module gowin_rpll_ctrl #(
  parameter logic [5:0] INIT_IDSEL   = 6'd0,
  parameter logic [5:0] INIT_FBDSEL  = 6'd0,
  parameter logic [5:0] INIT_ODSEL   = 6'd0,
  parameter logic [3:0] INIT_PSDA    = 4'd0,
  parameter logic [3:0] INIT_DUTYDA  = 4'd8,
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_STABLE  = 1024,
  parameter int         LOCK_TIMEOUT = 65536,
  parameter int         MAX_RETRY    = 3,
  parameter int         SETTLE       = 64
) (
  input  logic                    clkin,
  input  logic                    reset,
  gowin_rpll_ctrl_if.slave        req,
  input  logic                    pll_lock,
  output logic                    pll_reset,
  output logic [5:0]              idsel,
  output logic [5:0]              fbdsel,
  output logic [5:0]              odsel,
  output logic [3:0]              psda,
  output logic [3:0]              dutyda,
  output logic                    locked,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    S_RST_HOLD  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_IDLE      = 3'd2,
    S_PH_SETTLE = 3'd3,
    S_ERROR     = 3'd4
  } state_e;

  localparam int RST_W    = $clog2(RST_CYCLES + 1);
  localparam int STABLE_W = $clog2(LOCK_STABLE + 1);
  localparam int TO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  localparam logic [RST_W-1:0]    RST_LAST     = RST_W'(RST_CYCLES - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0]     TIMEOUT_LAST = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX    = RETRY_W'(MAX_RETRY);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST  = SETTLE_W'(SETTLE - 1);

  state_e              state_q, state_d;
  logic                lock_meta_q, lock_sync_q;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [STABLE_W-1:0] stable_q, stable_d;
  logic [TO_W-1:0]     timeout_q, timeout_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [5:0]          idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
  logic [3:0]          psda_q, psda_d, dutyda_q, dutyda_d;
  logic                pll_reset_q, pll_reset_d;
  logic                req_ready_q, req_ready_d;
  logic                locked_q, locked_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                success;
  logic                accept;

  // req_ready_q is high exactly in IDLE/ERROR, so this is the handshake.
  assign accept = req.req_valid && req_ready_q;

  // State and output registers.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q      <= S_RST_HOLD;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
      rst_cnt_q    <= '0;
      stable_q     <= '0;
      timeout_q    <= '0;
      retry_q      <= '0;
      settle_cnt_q <= '0;
      idsel_q      <= INIT_IDSEL;
      fbdsel_q     <= INIT_FBDSEL;
      odsel_q      <= INIT_ODSEL;
      psda_q       <= INIT_PSDA;
      dutyda_q     <= INIT_DUTYDA;
      pll_reset_q  <= 1'b1;
      req_ready_q  <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_meta_q  <= pll_lock;
      lock_sync_q  <= lock_meta_q;
      rst_cnt_q    <= rst_cnt_d;
      stable_q     <= stable_d;
      timeout_q    <= timeout_d;
      retry_q      <= retry_d;
      settle_cnt_q <= settle_cnt_d;
      idsel_q      <= idsel_d;
      fbdsel_q     <= fbdsel_d;
      odsel_q      <= odsel_d;
      psda_q       <= psda_d;
      dutyda_q     <= dutyda_d;
      pll_reset_q  <= pll_reset_d;
      req_ready_q  <= req_ready_d;
      locked_q     <= locked_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state, counters and select registers. Each counter only advances
  // in its owning state and is held at zero everywhere else, so every entry
  // into a state starts from a clean count.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = '0;
    stable_d     = '0;
    timeout_d    = '0;
    settle_cnt_d = '0;
    retry_d      = retry_q;
    idsel_d      = idsel_q;
    fbdsel_d     = fbdsel_q;
    odsel_d      = odsel_q;
    psda_d       = psda_q;
    dutyda_d     = dutyda_q;
    success      = 1'b0;
    case (state_q)
      S_RST_HOLD: begin
        if (rst_cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_WAIT_LOCK: begin
        stable_d  = lock_sync_q ? stable_q + 1'b1 : '0;
        timeout_d = timeout_q + 1'b1;
        // Lock success is tested first so it wins over a coincident timeout.
        if (lock_sync_q && stable_q == STABLE_LAST) begin
          state_d = S_IDLE;
          retry_d = '0;
          success = 1'b1;
        end else if (timeout_q == TIMEOUT_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d < RETRY_MAX) ? S_RST_HOLD : S_ERROR;
        end
      end
      S_IDLE: begin
        if (accept) begin
          psda_d   = req.req_psda;
          dutyda_d = req.req_dutyda;
          if (req.req_full) begin
            idsel_d  = req.req_idsel;
            fbdsel_d = req.req_fbdsel;
            odsel_d  = req.req_odsel;
            state_d  = S_RST_HOLD;
          end else begin
            state_d = S_PH_SETTLE;
          end
        end
        // A lock loss overrides the request path; the request has still been
        // consumed (ready was high), its selects apply to the relock.
        if (!lock_sync_q) begin
          state_d = S_RST_HOLD;
          retry_d = '0;
        end
      end
      S_PH_SETTLE: begin
        if (!lock_sync_q) begin
          state_d = S_RST_HOLD;
          retry_d = '0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_IDLE;
          success = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      S_ERROR: begin
        // Recovery always needs a full relock, whatever req_full says.
        if (accept) begin
          idsel_d  = req.req_idsel;
          fbdsel_d = req.req_fbdsel;
          odsel_d  = req.req_odsel;
          psda_d   = req.req_psda;
          dutyda_d = req.req_dutyda;
          retry_d  = '0;
          state_d  = S_RST_HOLD;
        end
      end
      default: state_d = S_RST_HOLD;
    endcase
  end

  // Registered outputs follow the next state so they line up with it.
  always_comb begin
    pll_reset_d = (state_d == S_RST_HOLD) || (state_d == S_ERROR);
    req_ready_d = (state_d == S_IDLE) || (state_d == S_ERROR);
    locked_d    = (state_d == S_IDLE) || (state_d == S_PH_SETTLE);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_ERROR));
    err_d       = (state_d == S_ERROR);
    done_d      = success;
  end

  assign req.req_ready = req_ready_q;
  assign pll_reset     = pll_reset_q;
  assign idsel         = idsel_q;
  assign fbdsel        = fbdsel_q;
  assign odsel         = odsel_q;
  assign psda          = psda_q;
  assign dutyda        = dutyda_q;
  assign locked        = locked_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign state_o       = state_q;

endmodule
